bc_msg_arbiter: RTL and testbench
=================================

// Module: bc_msg_arbiter
// PURPOSE
//  Collects broadcast messages from CORE_COUNT core wrappers (bc_msg_out/valid/ready)
//  and serialises them round-robin onto one broadcast bus fed back to every core's
//  bc_msg_in/bc_msg_in_valid. The bus has no backpressure. Cores held in reset are
//  masked: their pending messages are drained and counted as drops.
// PARAMETERS
//  CORE_COUNT     8    number of requesting cores (>=2)
//  CORE_ID_WIDTH  3    $clog2(CORE_COUNT), width of source index
//  MSG_WIDTH      47   broadcast message width (32 data + 4 strb + addr bits)
// PORTS
//  clk            in   1                     clock
//  rst            in   1                     synchronous, active-high reset
//  s_msg          in   CORE_COUNT*MSG_WIDTH  core i message at [i*MSG_WIDTH +: MSG_WIDTH]
//  s_valid        in   CORE_COUNT            per-core message valid
//  s_ready        out  CORE_COUNT            per-core accept (combinational)
//  core_mask      in   CORE_COUNT            1 = core active; 0 = in reset, drain and drop
//  halt           in   1                     1 = accept nothing from active cores
//  m_msg          out  MSG_WIDTH             broadcast message (registered)
//  m_src          out  CORE_ID_WIDTH         index of the source core
//  m_valid        out  1                     one-cycle pulse per message; no ready
//  bc_count       out  32                    messages broadcast since reset (wraps)
//  drop_count     out  32                    masked-core messages dropped (wraps)
// BEHAVIOUR
//  - Reset: m_valid=0, m_msg=0, m_src=0, prio_ptr=0, bc_count=0, drop_count=0.
//  - Request vector: req = s_valid & core_mask & {CORE_COUNT{~halt}}.
//  - Grant: the first set req bit at or after prio_ptr, circular search with wrap
//    from CORE_COUNT-1 to 0. At most one active grant per cycle.
//  - s_ready[i] = (grant==i & req[i]) | ~core_mask[i]. Masked cores always see
//    ready=1, including during halt.
//  - Transfer on s_valid[i] & s_ready[i]:
//    - Active core: next cycle m_valid=1, m_msg=s_msg[i], m_src=i,
//      bc_count+=1, prio_ptr <= (i==CORE_COUNT-1) ? 0 : i+1.
//    - Masked core: drop_count += 1 per dropped message. Several masked cores
//      in one cycle add popcount(s_valid & ~core_mask).
//    - Drops never assert m_valid and never move prio_ptr.
//  - No active grant: m_valid=0 next cycle. m_msg and m_src hold their last
//    values. prio_ptr holds.
//  - Latency and throughput: 1 cycle from accept to m_valid; sustained 1 msg/cycle.
//    Under full load each active core gets 1 slot per N active cores.
//  - halt=1: no active accepts from the next edge; m_valid drops after the
//    in-flight message. Deassert resumes at the stored prio_ptr.
//  - core_mask change mid-stream: takes effect the same cycle (combinational).
//    A message already registered on m_* still broadcasts.
//  - Counters wrap at 2^32 without saturation.
//  - rst mid-stream: all state clears at the edge. A message accepted in that
//    cycle is lost and not counted.
// STRUCTURE
//  - Shared header: MSG_WIDTH derivation (32+4+$clog2(BC_REGION_SIZE)-2) and
//    CORE_ID_WIDTH, common with the core wrapper.
//  - Sub-module bc_rr_grant: combinational, (req, prio_ptr) -> one-hot grant
//    plus encoded index and any_grant. The top level holds the pointer, the
//    output register and the counters.
// TESTING
//  1 Single request: core 3 sends msg 47'h1234, mask all 1
//    -> s_ready[3]=1 same cycle; next cycle m_valid=1, m_msg=47'h1234,
//       m_src=3, bc_count=1.
//  2 Full load: all 8 valid, 24 cycles
//    -> m_src sequence 0,1,..,7 repeated 3 times; m_valid high every cycle;
//       each core accepted exactly 3 times.
//  3 Wrap: prio_ptr=7, cores 7 and 0 valid
//    -> grant 7, then 0; prio_ptr returns to 1.
//  4 Mask: core_mask[5]=0, core 5 valid for 4 cycles
//    -> s_ready[5]=1 all 4 cycles, drop_count=4, no m_valid from src 5.
//       Core 2 concurrently valid gets all grants.
//  5 Halt: halt=1 for 5 cycles with cores 1 and 4 valid
//    -> s_ready=0 for both, m_valid=0 after one in-flight cycle.
//       After release, grants resume at the stored prio_ptr.
//  6 Reset mid-stream: rst during full load
//    -> next cycle m_valid=0, both counters 0; first grant after release is core 0.

Source files
------------

// File: rtl/bc_msg_arbiter_pkg.sv
// Shared definitions for the broadcast message arbiter and the core wrapper:
// message/core-index widths and small helpers.
package bc_msg_arbiter_pkg;

  localparam int unsigned BC_REGION_SIZE    = 8192;
  localparam int unsigned DEF_CORE_COUNT    = 8;
  localparam int unsigned DEF_CORE_ID_WIDTH = $clog2(DEF_CORE_COUNT);
  // 32 data bits + 4 byte strobes + word address within the broadcast region
  localparam int unsigned DEF_MSG_WIDTH     = 32 + 4 + $clog2(BC_REGION_SIZE) - 2;
  localparam int unsigned CNT_WIDTH         = 32;

  function automatic logic [CNT_WIDTH-1:0] count_ones(input logic [63:0] v);
    logic [CNT_WIDTH-1:0] n;
    n = '0;
    for (int i = 0; i < 64; i++) begin
      n = n + CNT_WIDTH'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/bc_msg_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or after the priority
// pointer, searching circularly.
module bc_rr_grant
  import bc_msg_arbiter_pkg::*;
#(
  parameter int unsigned N   = DEF_CORE_COUNT,
  parameter int unsigned IDW = DEF_CORE_ID_WIDTH
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] prio_ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           any_grant
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx       = 0;
    for (int k = int'(N) - 1; k >= 0; k--) begin
      idx = (int'(prio_ptr) + k) % int'(N);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = IDW'(idx);
        any_grant  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/bc_msg_arbiter.sv
// Round-robin serialiser of per-core broadcast messages onto a single
// no-backpressure bus; masked cores are drained and their messages counted.
module bc_msg_arbiter
  import bc_msg_arbiter_pkg::*;
#(
  parameter int unsigned CORE_COUNT    = DEF_CORE_COUNT,
  parameter int unsigned CORE_ID_WIDTH = $clog2(CORE_COUNT),
  parameter int unsigned MSG_WIDTH     = DEF_MSG_WIDTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [CORE_COUNT*MSG_WIDTH-1:0] s_msg,
  input  logic [CORE_COUNT-1:0]           s_valid,
  output logic [CORE_COUNT-1:0]           s_ready,
  input  logic [CORE_COUNT-1:0]           core_mask,
  input  logic                            halt,
  output logic [MSG_WIDTH-1:0]            m_msg,
  output logic [CORE_ID_WIDTH-1:0]        m_src,
  output logic                            m_valid,
  output logic [CNT_WIDTH-1:0]            bc_count,
  output logic [CNT_WIDTH-1:0]            drop_count
);

  typedef struct packed {
    logic [MSG_WIDTH-1:0]     msg;
    logic [CORE_ID_WIDTH-1:0] src;
  } bc_beat_t;

  logic [CORE_COUNT-1:0]    req_c;
  logic [CORE_COUNT-1:0]    grant_c;
  logic [CORE_COUNT-1:0]    drop_vec_c;
  logic [CORE_ID_WIDTH-1:0] grant_idx_c;
  logic                     any_grant_c;
  logic [CNT_WIDTH-1:0]     drop_inc_c;

  logic [CORE_ID_WIDTH-1:0] prio_ptr_q, prio_ptr_d;
  bc_beat_t                 beat_q, beat_d;
  logic                     m_valid_q, m_valid_d;
  logic [CNT_WIDTH-1:0]     bc_count_q, bc_count_d;
  logic [CNT_WIDTH-1:0]     drop_count_q, drop_count_d;

  assign req_c      = s_valid & core_mask & {CORE_COUNT{~halt}};
  assign drop_vec_c = s_valid & ~core_mask;
  assign drop_inc_c = count_ones(64'(drop_vec_c));

  bc_rr_grant #(
    .N   (CORE_COUNT),
    .IDW (CORE_ID_WIDTH)
  ) u_rr_grant (
    .req       (req_c),
    .prio_ptr  (prio_ptr_q),
    .grant     (grant_c),
    .grant_idx (grant_idx_c),
    .any_grant (any_grant_c)
  );

  // Masked cores are always ready so their pending messages drain, even under halt.
  assign s_ready = (grant_c & req_c) | ~core_mask;

  // Next-state: register the granted message; drops only bump the drop counter.
  always_comb begin
    prio_ptr_d   = prio_ptr_q;
    beat_d       = beat_q;
    m_valid_d    = 1'b0;
    bc_count_d   = bc_count_q;
    drop_count_d = drop_count_q + drop_inc_c;
    if (any_grant_c) begin
      m_valid_d  = 1'b1;
      beat_d.src = grant_idx_c;
      for (int i = 0; i < int'(CORE_COUNT); i++) begin
        if (grant_c[i]) begin
          beat_d.msg = s_msg[i*MSG_WIDTH +: MSG_WIDTH];
        end
      end
      bc_count_d = bc_count_q + CNT_WIDTH'(1);
      prio_ptr_d = (grant_idx_c == CORE_ID_WIDTH'(CORE_COUNT - 1))
                 ? '0 : grant_idx_c + CORE_ID_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_ptr_q   <= '0;
      beat_q       <= '0;
      m_valid_q    <= 1'b0;
      bc_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      prio_ptr_q   <= prio_ptr_d;
      beat_q       <= beat_d;
      m_valid_q    <= m_valid_d;
      bc_count_q   <= bc_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign m_msg      = beat_q.msg;
  assign m_src      = beat_q.src;
  assign m_valid    = m_valid_q;
  assign bc_count   = bc_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_bc_msg_arbiter.sv
// Directed plus randomized bench for bc_msg_arbiter against a cycle-level
// behavioural model of the arbitration rules.
module tb_bc_msg_arbiter;

  localparam int N  = 8;
  localparam int IW = 3;
  localparam int MW = 47;

  logic              clk = 1'b0;
  logic              rst;
  logic [N*MW-1:0]   s_msg;
  logic [N-1:0]      s_valid;
  logic [N-1:0]      s_ready;
  logic [N-1:0]      core_mask;
  logic              halt;
  logic [MW-1:0]     m_msg;
  logic [IW-1:0]     m_src;
  logic              m_valid;
  logic [31:0]       bc_count;
  logic [31:0]       drop_count;

  bc_msg_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .s_msg      (s_msg),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .core_mask  (core_mask),
    .halt       (halt),
    .m_msg      (m_msg),
    .m_src      (m_src),
    .m_valid    (m_valid),
    .bc_count   (bc_count),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model state
  int          md_ptr;
  logic        md_valid;
  logic [MW-1:0] md_msg;
  int          md_src;
  longint      md_bc;
  longint      md_drop;
  int          accepts [N];
  int          last_grant;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_msg(input int i, input logic [MW-1:0] v);
    s_msg[i*MW +: MW] = v;
  endtask

  function automatic logic [MW-1:0] rnd_msg();
    logic [63:0] w;
    w = {$urandom(), $urandom()};
    return w[MW-1:0];
  endfunction

  task automatic rand_all_msgs();
    for (int i = 0; i < N; i++) set_msg(i, rnd_msg());
  endtask

  // One clock: check ready before the edge, advance model, check registered outputs after.
  task automatic step(input string tag);
    logic [N-1:0] r, exp_ready, drops;
    int g;
    #1;
    r = s_valid & core_mask & {N{~halt}};
    g = pick(r, md_ptr);
    for (int i = 0; i < N; i++) exp_ready[i] = (g == i) || !core_mask[i];
    if (!rst) chk({tag, "_ready"}, 64'(s_ready), 64'(exp_ready));
    drops = s_valid & ~core_mask;
    @(posedge clk);
    if (rst) begin
      md_ptr = 0; md_valid = 1'b0; md_msg = '0; md_src = 0; md_bc = 0; md_drop = 0;
      last_grant = -1;
    end else begin
      md_drop = (md_drop + $countones(drops)) % (64'd1 << 32);
      last_grant = g;
      if (g >= 0) begin
        md_valid = 1'b1;
        md_msg   = s_msg[g*MW +: MW];
        md_src   = g;
        md_bc    = (md_bc + 1) % (64'd1 << 32);
        md_ptr   = (g + 1) % N;
        accepts[g]++;
      end else begin
        md_valid = 1'b0;
      end
    end
    #1;
    chk({tag, "_m_valid"}, 64'(m_valid), 64'(md_valid));
    chk({tag, "_m_msg"}, 64'(m_msg), 64'(md_msg));
    chk({tag, "_m_src"}, 64'(m_src), 64'(md_src));
    chk({tag, "_bc_count"}, 64'(bc_count), 64'(md_bc));
    chk({tag, "_drop_count"}, 64'(drop_count), 64'(md_drop));
  endtask

  task automatic clr_accepts();
    for (int i = 0; i < N; i++) accepts[i] = 0;
  endtask

  initial begin
    longint drop_base;
    md_ptr = 0; md_valid = 1'b0; md_msg = '0; md_src = 0; md_bc = 0; md_drop = 0;
    last_grant = -1;
    clr_accepts();
    rst = 1'b1; s_msg = '0; s_valid = '0; core_mask = '1; halt = 1'b0;
    step("reset");
    step("reset");
    chk("reset_valid", 64'(m_valid), 64'd0);
    chk("reset_bc", 64'(bc_count), 64'd0);
    rst = 1'b0;

    // Single request from core 3
    set_msg(3, 47'h1234); s_valid = 8'b0000_1000;
    #1 chk("t1_ready3", 64'(s_ready[3]), 64'd1);
    step("t1");
    chk("t1_msg", 64'(m_msg), 64'h1234);
    chk("t1_src", 64'(m_src), 64'd3);
    chk("t1_bc", 64'(bc_count), 64'd1);
    s_valid = '0;
    step("t1_idle");
    chk("t1_idle_valid", 64'(m_valid), 64'd0);

    // Full load from a fresh pointer
    rst = 1'b1; step("t2_rst"); rst = 1'b0;
    clr_accepts();
    s_valid = '1;
    for (int c = 0; c < 24; c++) begin
      rand_all_msgs();
      step("t2");
      chk("t2_seq_src", 64'(m_src), 64'(c % N));
      chk("t2_seq_valid", 64'(m_valid), 64'd1);
    end
    for (int i = 0; i < N; i++) chk("t2_accepts", 64'(accepts[i]), 64'd3);

    // Wrap from pointer 7 back to 0
    s_valid = 8'b0100_0000; step("t3_prime");
    s_valid = 8'b1000_0001; step("t3");
    chk("t3_first", 64'(m_src), 64'd7);
    s_valid = 8'b0000_0001; step("t3");
    chk("t3_second", 64'(m_src), 64'd0);
    s_valid = 8'b0000_0011; step("t3");
    chk("t3_ptr1", 64'(m_src), 64'd1);

    // Masked core 5 drains alongside active core 2
    drop_base = md_drop;
    core_mask = 8'b1101_1111; s_valid = 8'b0010_0100;
    for (int c = 0; c < 4; c++) begin
      rand_all_msgs();
      #1 chk("t4_ready5", 64'(s_ready[5]), 64'd1);
      step("t4");
      chk("t4_src", 64'(m_src), 64'd2);
    end
    chk("t4_drops", 64'(drop_count), 64'(drop_base + 4));
    core_mask = '1; s_valid = '0;

    // Halt with cores 1 and 4 pending
    s_valid = 8'b0001_0010;
    step("t5_pre");
    chk("t5_pre_src", 64'(m_src), 64'd4);
    halt = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1 chk("t5_ready", 64'(s_ready & 8'b0001_0010), 64'd0);
      step("t5");
      chk("t5_valid", 64'(m_valid), 64'd0);
    end
    halt = 1'b0;
    step("t5_resume");
    chk("t5_resume_src", 64'(m_src), 64'd1);

    // Reset during full load
    s_valid = '1;
    for (int c = 0; c < 5; c++) begin rand_all_msgs(); step("t6_load"); end
    rst = 1'b1; step("t6_rst");
    chk("t6_valid", 64'(m_valid), 64'd0);
    chk("t6_bc", 64'(bc_count), 64'd0);
    chk("t6_drop", 64'(drop_count), 64'd0);
    rst = 1'b0;
    step("t6_after");
    chk("t6_first", 64'(m_src), 64'd0);

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      rand_all_msgs();
      s_valid   = N'($urandom());
      core_mask = ($urandom_range(0, 3) == 0) ? N'($urandom()) : '1;
      halt      = ($urandom_range(0, 9) == 0);
      rst       = ($urandom_range(0, 59) == 0);
      step("rand");
    end
    rst = 1'b0; halt = 1'b0; s_valid = '0; core_mask = '1;
    step("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
